// File: rtl/ru_mem_responder_if.sv
// ---------------------------------------------------------------------------
// Module : ru_mem_responder_if
// Brief  : Request-unit / RAM-port signal bundle for ru_mem_responder.
//          slave  = the responder's view, master = requester/RAM view.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ru_mem_responder_if;
  // request unit side
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  // backing RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  // status
  logic        bus_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/ru_mem_responder.sv
// ---------------------------------------------------------------------------
// Module : ru_mem_responder
// Brief  : Arbitrates instruction/data requests onto one RAM port, returns
//          single-cycle hit pulses, aborts stalled accesses after TIMEOUT
//          cycles and keeps a sticky bus-error flag.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ru_mem_responder #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic               CLK,
  input  logic               RST,
  ru_mem_responder_if.slave  bus
);

  // Counter is wide enough to hold TIMEOUT itself, so no wrap concerns.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_IRD = 2'd0,
    OP_DRD = 2'd1,
    OP_DWR = 2'd2
  } op_t;

  state_t           state, next_state;
  op_t              op;
  logic [31:0]      addr;
  logic [31:0]      store;
  logic             last_grant_d;   // 0 = last grant went to I, 1 = to D
  logic [CNT_W-1:0] cnt;
  logic [31:0]      iload_r;
  logic [31:0]      dload_r;
  logic             bus_err_r;

  logic             d_req;
  logic             grant_i;
  logic             grant_d;
  logic             timeout_hit;
  logic             ram_ren;
  logic             ram_wen;
  logic             ihit_c;
  logic             dhit_c;

  // dREN together with dWEN counts as a single data (write) request.
  assign d_req = bus.dREN | bus.dWEN;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state, arbitration and strobe/hit decode.
  always_comb begin
    next_state  = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    timeout_hit = 1'b0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ihit_c      = 1'b0;
    dhit_c      = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless it also won last time and I is waiting.
        grant_i = bus.iREN & (~d_req | last_grant_d);
        grant_d = d_req & ~grant_i;
        if (grant_i | grant_d) next_state = ACCESS;
      end
      ACCESS: begin
        ram_ren = (op != OP_DWR);
        ram_wen = (op == OP_DWR);
        if (bus.ram_ready) begin
          next_state = RESP;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          next_state  = RESP;
        end
      end
      RESP: begin
        ihit_c     = (op == OP_IRD);
        dhit_c     = (op != OP_IRD);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, wait counter, load capture and sticky error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op           <= OP_IRD;
      addr         <= 32'h0;
      store        <= 32'h0;
      last_grant_d <= 1'b0;
      cnt          <= '0;
      iload_r      <= 32'h0;
      dload_r      <= 32'h0;
      bus_err_r    <= 1'b0;
    end else begin
      if (grant_i) begin
        op           <= OP_IRD;
        addr         <= bus.iaddr & ~32'h3;
        store        <= bus.dstore;
        last_grant_d <= 1'b0;
      end else if (grant_d) begin
        op           <= bus.dWEN ? OP_DWR : OP_DRD;
        addr         <= bus.daddr & ~32'h3;
        store        <= bus.dstore;
        last_grant_d <= 1'b1;
      end

      if (state == ACCESS && !bus.ram_ready && !timeout_hit) cnt <= cnt + 1'b1;
      else if (state != ACCESS)                              cnt <= '0;

      if (state == ACCESS) begin
        if (bus.ram_ready) begin
          if (op == OP_IRD) iload_r <= bus.ramload;
          if (op == OP_DRD) dload_r <= bus.ramload;
        end else if (timeout_hit) begin
          bus_err_r <= 1'b1;
          if (op == OP_IRD) iload_r <= ERR_WORD;
          if (op == OP_DRD) dload_r <= ERR_WORD;
        end
      end
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.ihit     = ihit_c;
  assign bus.dhit     = dhit_c;
  assign bus.iload    = iload_r;
  assign bus.dload    = dload_r;
  assign bus.bus_err  = bus_err_r;

endmodule

`default_nettype wire

// File: tb/tb_ru_mem_responder.sv
// ---------------------------------------------------------------------------
// Module : tb_ru_mem_responder
// Brief  : Directed self-checking bench for ru_mem_responder (TIMEOUT=4).
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ru_mem_responder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  ru_mem_responder_if bus ();

  ru_mem_responder #(.TIMEOUT(4), .ERR_WORD(32'hBAD1BAD1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #3;
    vectors++;
    if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.bus_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.bus_err});
    end
    vectors++;
    if ({bus.iload, bus.dload, bus.ramaddr, bus.ramstore} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0",
               bus.iload, bus.dload, bus.ramaddr, bus.ramstore);
    end
    @(negedge CLK);
    RST = 1'b0;
    // Start an I read, then reset in the middle of the access.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0010;
    tick();
    bus.iREN = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus.ramREN !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_strobe: got ramREN=%b expected 1", bus.ramREN);
    end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.bus_err} !== 5'b0 || bus.ramaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_access: got strobes/hits/err=%b ramaddr=%h expected 0",
               {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.bus_err}, bus.ramaddr);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      vectors++;
      if ({bus.ihit, bus.dhit, bus.ramREN} !== 3'b0) begin
        miscompares++;
        $display("FAIL reset_no_hit: cycle %0d got ihit/dhit/ramREN=%b expected 000",
                 c, {bus.ihit, bus.dhit, bus.ramREN});
      end
    end
  endtask

  task automatic test_iread();
    tick();                                    // cycle 0
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0042;
    @(negedge CLK);
    vectors++;
    if (bus.ramREN !== 1'b0) begin
      miscompares++;
      $display("FAIL iread_c0_strobe: got %b expected 0", bus.ramREN);
    end
    tick();                                    // cycle 1
    bus.ram_ready = 1'b1; bus.ramload = 32'h8C22_0004;
    @(negedge CLK);
    vectors++;
    if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0000_0040 || bus.ihit !== 1'b0) begin
      miscompares++;
      $display("FAIL iread_c1: got ramREN=%b ramWEN=%b ramaddr=%h ihit=%b expected 1 0 00000040 0",
               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ihit);
    end
    tick();                                    // cycle 2
    bus.ram_ready = 1'b0; bus.iREN = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b1 || bus.dhit !== 1'b0 || bus.iload !== 32'h8C22_0004 || bus.ramREN !== 1'b0) begin
      miscompares++;
      $display("FAIL iread_hit: got ihit=%b dhit=%b iload=%h ramREN=%b expected 1 0 8c220004 0",
               bus.ihit, bus.dhit, bus.iload, bus.ramREN);
    end
    tick();                                    // cycle 3
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b0 || bus.iload !== 32'h8C22_0004) begin
      miscompares++;
      $display("FAIL iread_hold: got ihit=%b iload=%h expected 0 8c220004", bus.ihit, bus.iload);
    end
  endtask

  task automatic test_dwrite();
    tick();                                    // cycle 0
    bus.dWEN = 1'b1; bus.daddr = 32'h0000_0100; bus.dstore = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.dWEN = 1'b0;                         // withdrawn; access must still finish
      bus.dstore = 32'h0;
      bus.ram_ready = (c == 3);
      @(negedge CLK);
      vectors++;
      if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'hDEAD_BEEF ||
          bus.ramaddr !== 32'h0000_0100 || bus.dhit !== 1'b0) begin
        miscompares++;
        $display("FAIL dwrite_c%0d: got ramWEN=%b ramREN=%b ramstore=%h ramaddr=%h dhit=%b expected 1 0 deadbeef 00000100 0",
                 c, bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr, bus.dhit);
      end
    end
    tick();                                    // cycle 4
    bus.ram_ready = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus.dhit !== 1'b1 || bus.ihit !== 1'b0 || bus.dload !== 32'h0 || bus.ramWEN !== 1'b0) begin
      miscompares++;
      $display("FAIL dwrite_hit: got dhit=%b ihit=%b dload=%h ramWEN=%b expected 1 0 00000000 0",
               bus.dhit, bus.ihit, bus.dload, bus.ramWEN);
    end
  endtask

  task automatic test_contention();
    logic [31:0] order [4];
    logic [31:0] exp_order [4];
    int          grants = 0;
    int          cyc = 0;
    logic        prev_str = 1'b0;
    exp_order[0] = 32'h300; exp_order[1] = 32'h200;
    exp_order[2] = 32'h300; exp_order[3] = 32'h200;
    for (int g = 0; g < 4; g++) order[g] = 32'hFFFF_FFFF;
    // Fresh reset so the first contended grant starts from last_grant=I.
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    tick();
    bus.iaddr = 32'h200; bus.daddr = 32'h300; bus.iREN = 1'b1; bus.dREN = 1'b1; bus.dWEN = 1'b0;
    while (grants < 4 && cyc < 40) begin
      @(negedge CLK);
      if (bus.ramREN && !prev_str) begin
        order[grants] = bus.ramaddr;
        grants++;
      end
      prev_str = bus.ramREN;
      // One-cycle RAM: answer with address+1 in the same cycle.
      bus.ram_ready = bus.ramREN;
      bus.ramload   = bus.ramaddr + 32'h1;
      if (bus.ihit) begin
        bus.iREN = 1'b0;
        vectors++;
        if (bus.iload !== 32'h201) begin
          miscompares++;
          $display("FAIL contention_iload: got %h expected 00000201", bus.iload);
        end
      end
      if (bus.dhit) begin
        bus.dREN = 1'b0;
        vectors++;
        if (bus.dload !== 32'h301) begin
          miscompares++;
          $display("FAIL contention_dload: got %h expected 00000301", bus.dload);
        end
      end
      tick();
      bus.iREN = 1'b1; bus.dREN = 1'b1;
      cyc++;
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ram_ready = 1'b0;
    tick(); tick(); tick();
    for (int g = 0; g < 4; g++) begin
      vectors++;
      if (order[g] !== exp_order[g]) begin
        miscompares++;
        $display("FAIL contention_grant%0d: got ramaddr=%h expected %h", g, order[g], exp_order[g]);
      end
    end
  endtask

  task automatic test_timeout();
    int   str_cycles = 0;
    int   cyc = 0;
    logic seen = 1'b0;
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0044; bus.ram_ready = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge CLK);
      if (bus.ramREN) str_cycles++;
      if (bus.dhit) begin
        seen = 1'b1;
        vectors++;
        if (bus.dload !== 32'hBAD1_BAD1 || bus.bus_err !== 1'b1 || bus.ramREN !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_hit: got dload=%h bus_err=%b ramREN=%b expected bad1bad1 1 0",
                   bus.dload, bus.bus_err, bus.ramREN);
        end
      end else begin
        tick();
      end
      cyc++;
    end
    bus.dREN = 1'b0;
    vectors++;
    if (!seen || str_cycles != 4) begin
      miscompares++;
      $display("FAIL timeout_strobe_len: got seen=%b strobe_cycles=%0d expected 1 4", seen, str_cycles);
    end
    // A later successful access must leave bus_err set.
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0008;
    tick();
    bus.iREN = 1'b0; bus.ram_ready = 1'b1; bus.ramload = 32'h1111_2222;
    tick();
    bus.ram_ready = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h1111_2222 || bus.bus_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got ihit=%b iload=%h bus_err=%b expected 1 11112222 1",
               bus.ihit, bus.iload, bus.bus_err);
    end
    RST = 1'b1;
    #1;
    vectors++;
    if (bus.bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err_clear: got bus_err=%b expected 0", bus.bus_err);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_rw_both();
    int hits = 0;
    tick();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h0000_0083; bus.dstore = 32'h1234_5678;
    tick();
    bus.ram_ready = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'h1234_5678 || bus.ramaddr !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL rw_both_strobe: got ramWEN=%b ramREN=%b ramstore=%h ramaddr=%h expected 1 0 12345678 00000080",
               bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
    end
    tick();
    bus.ram_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (bus.dhit) begin
        hits++;
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
      end
      if (c == 0) begin
        vectors++;
        if (bus.dhit !== 1'b1 || bus.dload !== 32'h0) begin
          miscompares++;
          $display("FAIL rw_both_hit: got dhit=%b dload=%h expected 1 00000000", bus.dhit, bus.dload);
        end
      end
      tick();
    end
    vectors++;
    if (hits != 1) begin
      miscompares++;
      $display("FAIL rw_both_count: got %0d dhit pulses expected 1", hits);
    end
  endtask

  initial begin
    bus.iREN = 1'b0; bus.iaddr = 32'h0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = 32'h0; bus.dstore = 32'h0; bus.ramload = 32'h0; bus.ram_ready = 1'b0;
    test_reset();
    test_iread();
    test_dwrite();
    test_contention();
    test_timeout();
    test_rw_both();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
